// File: rtl/mmio_xbar_if.sv
// rtl/mmio_xbar_if.sv - request/response channels of two masters plus the shared slave bus
// Purpose: bundles everything that flows between the two bus masters, the crossbar and the
//          address-decoded slaves so the crossbar takes a single bus port.
// Ports (signals):
//   m0_*/m1_*  req, we, addr, wdata toward the crossbar; gnt, rvalid, rdata, err back
//   s_*        sel, we, addr, wdata toward the slaves; rdata (packed per slave), ready back
// Modports:
//   slave   the crossbar side: it serves the masters and drives the slave bus
//   master  the environment side: the masters and the slaves themselves
interface mmio_xbar_if #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int N_SLAVES = 5
);
   logic                       m0_req;
   logic                       m0_we;
   logic [ADDR_W-1:0]          m0_addr;
   logic [DATA_W-1:0]          m0_wdata;
   logic                       m0_gnt;
   logic                       m0_rvalid;
   logic [DATA_W-1:0]          m0_rdata;
   logic                       m0_err;

   logic                       m1_req;
   logic                       m1_we;
   logic [ADDR_W-1:0]          m1_addr;
   logic [DATA_W-1:0]          m1_wdata;
   logic                       m1_gnt;
   logic                       m1_rvalid;
   logic [DATA_W-1:0]          m1_rdata;
   logic                       m1_err;

   logic [N_SLAVES-1:0]        s_sel;
   logic                       s_we;
   logic [ADDR_W-1:0]          s_addr;
   logic [DATA_W-1:0]          s_wdata;
   logic [DATA_W*N_SLAVES-1:0] s_rdata;
   logic [N_SLAVES-1:0]        s_ready;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata, m0_err,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata, m1_err,
      output s_sel, s_we, s_addr, s_wdata,
      input  s_rdata, s_ready
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
      input  s_sel, s_we, s_addr, s_wdata,
      output s_rdata, s_ready
   );
endinterface

// File: rtl/mmio_xbar.sv
// rtl/mmio_xbar.sv - two-master round-robin crossbar onto address-decoded MMIO slaves
// Purpose: arbitrates m0/m1, runs one access at a time against the decoded slave (wait states
//          via s_ready, aborted after TIMEOUT cycles), returns rdata/err to the owning master and
//          records the address of the last failing access behind a sticky interrupt.
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   bus       master channels and slave bus (mmio_xbar_if.slave); interface parameters must
//             match ADDR_W/DATA_W/N_SLAVES
//   err_addr  address of the most recent errored access
//   err_irq   sticky error interrupt
//   err_clr   clears err_irq (a new error in the same cycle takes priority)
module mmio_xbar #(
   parameter int                        ADDR_W   = 32,
   parameter int                        DATA_W   = 32,
   parameter int                        N_SLAVES = 5,
   parameter logic [ADDR_W*N_SLAVES-1:0] SLV_BASE = {32'h4000_0020, 32'h4000_0010, 32'h4000_0008,
                                                     32'h4000_0000, 32'h0000_0000},
   parameter logic [ADDR_W*N_SLAVES-1:0] SLV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF8,
                                                     32'hFFFF_FFF8, 32'hFFFF_F000},
   parameter int                        TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              reset,
   mmio_xbar_if.slave        bus,
   output logic [ADDR_W-1:0] err_addr,
   output logic              err_irq,
   input  logic              err_clr
);
   localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t            state_q, state_d;
   logic              last_q;      // master granted last time: 0 = m0, 1 = m1
   logic              owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [IDX_W-1:0]  idx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              resp_err_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   logic              any_req, win, accept;
   logic [ADDR_W-1:0] win_addr;
   logic              win_we;
   logic [DATA_W-1:0] win_wdata;
   logic              dec_hit;
   logic [IDX_W-1:0]  dec_idx;
   logic              cur_ready, timed_out;
   logic [DATA_W-1:0] cur_rdata;
   logic              resp_load, resp_err_d, resp_owner;
   logic [DATA_W-1:0] resp_data_d;
   logic              gnt0, gnt1, rv0, rv1;

   assign any_req   = bus.m0_req | bus.m1_req;
   // Under contention the master that was not granted last wins, so grants alternate.
   assign win       = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;
   assign win_addr  = win ? bus.m1_addr  : bus.m0_addr;
   assign win_we    = win ? bus.m1_we    : bus.m0_we;
   assign win_wdata = win ? bus.m1_wdata : bus.m0_wdata;

   // Scanning from the top down leaves the lowest matching slave index.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((win_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
            dec_hit = 1'b1;
            dec_idx = IDX_W'(i);
         end
      end
   end

   assign cur_ready = bus.s_ready[idx_q];
   assign cur_rdata = bus.s_rdata[int'(idx_q)*DATA_W +: DATA_W];
   // cnt_q counts completed ACCESS cycles, so this is the TIMEOUT-th one.
   assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      resp_load   = 1'b0;
      resp_err_d  = 1'b0;
      resp_owner  = owner_q;
      resp_data_d = '0;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               accept     = 1'b1;
               gnt0       = ~win;
               gnt1       = win;
               resp_owner = win;
               if (dec_hit) begin
                  state_d = ACCESS;
               end else begin
                  state_d    = RESP;
                  resp_load  = 1'b1;
                  resp_err_d = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (cur_ready) begin
               state_d     = RESP;
               resp_load   = 1'b1;
               resp_data_d = we_q ? '0 : cur_rdata;
            end else if (timed_out) begin
               state_d    = RESP;
               resp_load  = 1'b1;
               resp_err_d = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         resp_err_q <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         err_addr   <= '0;
         err_irq    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q <= win;
            last_q  <= win;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            idx_q   <= dec_idx;
            cnt_q   <= '0;
         end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (resp_load) begin
            resp_err_q <= resp_err_d;
            if (resp_owner) rdata1_q <= resp_data_d;
            else            rdata0_q <= resp_data_d;
         end
         // A new error outranks a clear arriving in the same cycle.
         if (resp_load && resp_err_d) begin
            err_irq  <= 1'b1;
            err_addr <= (state_q == IDLE) ? win_addr : addr_q;
         end else if (err_clr) begin
            err_irq <= 1'b0;
         end
      end
   end

   assign rv0 = (state_q == RESP) & ~owner_q;
   assign rv1 = (state_q == RESP) &  owner_q;

   // gnt is combinational from req; gating with reset keeps it low while reset is held.
   assign bus.m0_gnt    = gnt0 & reset;
   assign bus.m1_gnt    = gnt1 & reset;
   assign bus.m0_rvalid = rv0;
   assign bus.m1_rvalid = rv1;
   assign bus.m0_rdata  = rdata0_q;
   assign bus.m1_rdata  = rdata1_q;
   assign bus.m0_err    = rv0 & resp_err_q;
   assign bus.m1_err    = rv1 & resp_err_q;

   assign bus.s_sel   = (state_q == ACCESS) ? (N_SLAVES'(1) << idx_q) : '0;
   assign bus.s_we    = (state_q == ACCESS) & we_q;
   assign bus.s_addr  = addr_q;
   assign bus.s_wdata = wdata_q;
endmodule

// File: tb/tb_mmio_xbar.sv
// tb/tb_mmio_xbar.sv - directed and randomized checks of mmio_xbar against a behavioural model
module tb_mmio_xbar;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 5;
   localparam int TO = 15;
   localparam logic [AW*NS-1:0] BASE = {32'h4000_0020, 32'h4000_0010, 32'h4000_0008,
                                        32'h4000_0000, 32'h0000_0000};
   localparam logic [AW*NS-1:0] MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF8,
                                        32'hFFFF_FFF8, 32'hFFFF_F000};

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          err_clr = 1'b0;
   logic [AW-1:0] err_addr;
   logic          err_irq;

   mmio_xbar_if #(.ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS)) bus ();

   mmio_xbar #(.ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS), .SLV_BASE(BASE), .SLV_MASK(MASK),
               .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .err_addr(err_addr), .err_irq(err_irq), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave models: slave i raises ready after wait_cfg[i] cycles of continuous select.
   logic [DW-1:0]    srd [NS];
   int               wait_cfg [NS];
   int               sel_run;
   logic [NS-1:0]    rdy_v;
   logic [DW*NS-1:0] rd_v;
   always @(posedge clk or negedge reset)
      if (!reset) sel_run <= 0;
      else        sel_run <= (bus.s_sel != '0) ? sel_run + 1 : 0;
   always_comb begin
      rdy_v = '0;
      rd_v  = '0;
      for (int i = 0; i < NS; i++) begin
         rdy_v[i]         = bus.s_sel[i] && (sel_run >= wait_cfg[i]);
         rd_v[i*DW +: DW] = srd[i];
      end
   end
   assign bus.s_ready = rdy_v;
   assign bus.s_rdata = rd_v;

   // Monitor: event log sampled on the falling edge.
   int            g_cyc [2];
   int            g_n [2];
   int            rv_cyc [2];
   int            rv_n [2];
   logic [DW-1:0] rv_data [2];
   logic          rv_err [2];
   int            gnt_order [$];
   int            both_rv = 0;
   int            sel_n = 0;
   int            sel_first = 0;
   logic          sel_prev = 1'b0;
   logic [NS-1:0] sel_val;
   logic [AW-1:0] sel_addr;
   logic          sel_we;
   logic [DW-1:0] sel_wdata;
   initial begin
      for (int i = 0; i < 2; i++) begin
         g_cyc[i] = 0; g_n[i] = 0; rv_cyc[i] = 0; rv_n[i] = 0; rv_data[i] = '0; rv_err[i] = 1'b0;
      end
   end
   always @(negedge clk) begin
      if (reset) begin
         if (bus.m0_gnt) begin g_cyc[0] = cyc; g_n[0]++; gnt_order.push_back(0); end
         if (bus.m1_gnt) begin g_cyc[1] = cyc; g_n[1]++; gnt_order.push_back(1); end
         if (bus.m0_rvalid) begin
            rv_cyc[0] = cyc; rv_n[0]++; rv_data[0] = bus.m0_rdata; rv_err[0] = bus.m0_err;
         end
         if (bus.m1_rvalid) begin
            rv_cyc[1] = cyc; rv_n[1]++; rv_data[1] = bus.m1_rdata; rv_err[1] = bus.m1_err;
         end
         if (bus.m0_rvalid && bus.m1_rvalid) both_rv++;
         if (bus.s_sel != '0) begin
            if (!sel_prev) sel_first = cyc;
            sel_n++;
            sel_val = bus.s_sel; sel_addr = bus.s_addr; sel_we = bus.s_we; sel_wdata = bus.s_wdata;
         end
         sel_prev = (bus.s_sel != '0);
      end
   end

   // Reference state for the error capture.
   logic          mdl_irq = 1'b0;
   logic [AW-1:0] mdl_eaddr = '0;
   logic [AW*NS-1:0] base_v, mask_v;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   function automatic int decode(input logic [AW-1:0] a);
      for (int i = 0; i < NS; i++)
         if ((a & mask_v[i*AW +: AW]) == base_v[i*AW +: AW]) return i;
      return -1;
   endfunction

   task automatic set_req(input int m, input logic r, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      if (m == 0) begin bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; end
      else        begin bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; end
   endtask

   // Holds req until gnt is seen, then drops it right after the accepting edge.
   task automatic issue(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n0;
      bit got;
      n0 = g_n[m];
      got = 1'b0;
      set_req(m, 1'b1, we, a, d);
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk); #1;
         got = (g_n[m] != n0);
      end
      check("gnt_seen", 64'(got), 64'd1);
      step();
      set_req(m, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic clear_irq();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      mdl_irq = 1'b0;
      check("irq_clr", 64'(err_irq), 64'd0);
   endtask

   // One access checked against the model; clr_at >= 0 pulses err_clr that many cycles after gnt.
   task automatic run_one(input string nm, input int m, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int clr_at);
      int sl, acc, lat, n0, o0, s0;
      logic e;
      logic [DW-1:0] rd;
      bit done;
      sl = decode(a);
      if (sl < 0) begin
         e = 1'b1; acc = 0; rd = '0;
      end else begin
         e   = (wait_cfg[sl] >= TO);
         acc = e ? TO : wait_cfg[sl] + 1;
         rd  = (e || we) ? '0 : srd[sl];
      end
      lat = acc + 1;
      n0 = rv_n[m]; o0 = rv_n[1-m]; s0 = sel_n;
      issue(m, we, a, d);
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         err_clr = (clr_at >= 0) && (cyc == g_cyc[m] + clr_at);
         @(negedge clk); #1;
         done = (rv_n[m] != n0);
         step();
      end
      err_clr = 1'b0;
      if (e) begin
         mdl_irq = 1'b1; mdl_eaddr = a;
      end else if (clr_at >= 0) begin
         mdl_irq = 1'b0;
      end
      check({nm, ".rv_count"}, 64'(rv_n[m] - n0), 64'd1);
      check({nm, ".latency"}, 64'(rv_cyc[m] - g_cyc[m]), 64'(lat));
      check({nm, ".rdata"}, 64'(rv_data[m]), 64'(rd));
      check({nm, ".err"}, 64'(rv_err[m]), 64'(e));
      check({nm, ".other_rv"}, 64'(rv_n[1-m] - o0), 64'd0);
      check({nm, ".sel_cycles"}, 64'(sel_n - s0), 64'(acc));
      if (sl >= 0) begin
         check({nm, ".sel"}, 64'(sel_val), 64'(1 << sl));
         check({nm, ".sel_start"}, 64'(sel_first - g_cyc[m]), 64'd1);
         check({nm, ".s_addr"}, 64'(sel_addr), 64'(a));
         check({nm, ".s_we"}, 64'(sel_we), 64'(we));
         if (we) check({nm, ".s_wdata"}, 64'(sel_wdata), 64'(d));
      end
      check({nm, ".err_irq"}, 64'(err_irq), 64'(mdl_irq));
      check({nm, ".err_addr"}, 64'(err_addr), 64'(mdl_eaddr));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n0a, n1a;
      logic [3:0] ord;
      base_v = BASE;
      mask_v = MASK;
      for (int i = 0; i < NS; i++) begin srd[i] = '0; wait_cfg[i] = 0; end
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);

      // Reset state
      step(); step();
      check("rst_ctl", 64'({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err,
                            bus.m1_err, bus.s_sel, bus.s_we, err_irq}), 64'd0);
      check("rst_data", 64'(bus.m0_rdata | bus.m1_rdata | bus.s_wdata), 64'd0);
      check("rst_addr", 64'(bus.s_addr | err_addr), 64'd0);
      reset = 1'b1;
      step();

      // Zero-wait read, wait states, write, unmapped, timeout with simultaneous clear
      srd[0] = 32'hDEAD_BEEF; wait_cfg[0] = 0;
      run_one("rd0", 0, 1'b0, 32'h0000_0010, '0, -1);
      srd[2] = 32'h1234_5678; wait_cfg[2] = 3;
      run_one("wait3", 0, 1'b0, 32'h4000_000C, '0, -1);
      wait_cfg[3] = 1;
      run_one("wr3", 1, 1'b1, 32'h4000_0014, 32'hCAFE_F00D, -1);
      run_one("unmap", 1, 1'b1, 32'h8000_0000, 32'h5555_AAAA, -1);
      clear_irq();
      wait_cfg[1] = 255;
      run_one("tmo", 0, 1'b0, 32'h4000_0004, '0, TO);

      // Randomized accesses
      for (int it = 0; it < 40; it++) begin
         int k, m;
         logic we;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         k  = $urandom_range(0, NS);
         m  = $urandom_range(0, 1);
         we = 1'($urandom_range(0, 1));
         d  = $urandom;
         for (int i = 0; i < NS; i++) srd[i] = $urandom;
         if (k == NS) begin
            a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
         end else begin
            wait_cfg[k] = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 4);
            a = base_v[k*AW +: AW] | ($urandom & ~mask_v[k*AW +: AW]);
         end
         run_one("rnd", m, we, a, d, -1);
         if ($urandom_range(0, 3) == 0) clear_irq();
      end

      // Contention from reset: both masters request continuously
      reset = 1'b0; mdl_irq = 1'b0; mdl_eaddr = '0;
      step(); step();
      reset = 1'b1;
      base = gnt_order.size(); n0a = rv_n[0]; n1a = rv_n[1];
      wait_cfg[0] = 0; wait_cfg[3] = 0; srd[0] = 32'hA0A0_0001; srd[3] = 32'hB3B3_0003;
      set_req(0, 1'b1, 1'b0, 32'h0000_0020, '0);
      set_req(1, 1'b1, 1'b0, 32'h4000_0018, '0);
      for (int k = 0; k < 100 && gnt_order.size() < base + 4; k++) begin @(negedge clk); #1; end
      step();
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      for (int k = 0; k < 20 && (rv_n[0] - n0a < 2 || rv_n[1] - n1a < 2); k++) begin
         @(negedge clk); #1;
      end
      step();
      ord = 4'hF;
      for (int i = 0; i < 4; i++) if (base + i < gnt_order.size()) ord[i] = gnt_order[base+i][0];
      check("cont_count", 64'(gnt_order.size() - base), 64'd4);
      check("cont_order", 64'(ord), 64'b1010);
      check("cont_rv0", 64'(rv_n[0] - n0a), 64'd2);
      check("cont_rv1", 64'(rv_n[1] - n1a), 64'd2);
      check("cont_rdata0", 64'(rv_data[0]), 64'(srd[0]));
      check("cont_rdata1", 64'(rv_data[1]), 64'(srd[3]));
      check("rv_exclusive", 64'(both_rv), 64'd0);

      // Reset during a wait-state access owned by m0
      wait_cfg[2] = 10; srd[2] = 32'h0F0F_0F0F;
      n0a = rv_n[0];
      issue(0, 1'b0, 32'h4000_0008, '0);
      step(); #3;
      check("mid_sel", 64'(bus.s_sel), 64'b00100);
      reset = 1'b0;
      #1;
      check("mrst_ctl", 64'({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err,
                             bus.m1_err, bus.s_sel, bus.s_we, err_irq}), 64'd0);
      check("mrst_data", 64'(bus.m0_rdata | bus.m1_rdata | bus.s_wdata), 64'd0);
      check("mrst_addr", 64'(bus.s_addr | err_addr), 64'd0);
      step(); step();
      reset = 1'b1;
      step(); step(); step();
      check("mrst_no_rv", 64'(rv_n[0] - n0a), 64'd0);
      base = gnt_order.size();
      wait_cfg[0] = 0;
      set_req(0, 1'b1, 1'b0, 32'h0000_0030, '0);
      set_req(1, 1'b1, 1'b0, 32'h4000_0018, '0);
      for (int k = 0; k < 20 && gnt_order.size() <= base; k++) begin @(negedge clk); #1; end
      step();
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      ord = 4'hF;
      if (gnt_order.size() > base) ord[0] = gnt_order[base][0];
      check("mrst_first_gnt", 64'(ord[0]), 64'd0);
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
